spi_master_mc: RTL and testbench

//  Fully synchronous, multi-slave SPI master; successor to the fixed-mode SPI master.

---
 rtl/spi_master_mc.sv | 178 +++++++++++++++++
 tb/tb_spi_master_mc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-slave SPI master with runtime CPOL/CPHA, programmable divider and SS-held bursts.
// Defining SPI_MASTER_LSB_FIRST_EN adds the LsbFirst port for LSB-first transfers.
module spi_master_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SS     = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                                        Clk,
    input  logic                                        Reset_n,
    input  logic                                        TxValid,
    output logic                                        TxReady,
    input  logic [DATA_WIDTH-1:0]                       TxData,
    input  logic                                        TxLast,
    input  logic [(NUM_SS > 1 ? $clog2(NUM_SS) : 1)-1:0] SsSel,
    input  logic                                        Cpol,
    input  logic                                        Cpha,
    input  logic [DIV_WIDTH-1:0]                        ClkDiv,
    output logic                                        RxValid,
    output logic [DATA_WIDTH-1:0]                       RxData,
    output logic                                        Busy,
    output logic                                        SClk,
    output logic                                        MOSI,
    input  logic                                        MISO,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic                                        LsbFirst,
`endif
    output logic [NUM_SS-1:0]                           SS_n
);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, SETUP, LEAD, TRAIL, WAIT, CSHOLD} state_t;

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
    logic [NUM_SS-1:0]     ss_n_q, ss_n_d;
    logic                  rx_valid_q, rx_valid_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, last_q, last_d;
    logic                  tick, lead, trail, lsb_in, out_bit;
    logic [DATA_WIDTH-1:0] tx_shift, rx_shift;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = LsbFirst;
`else
    assign lsb_in = 1'b0;
`endif

    assign out_bit  = lsb_q ? tx_q[0] : tx_q[DATA_WIDTH-1];
    assign tx_shift = lsb_q ? tx_q >> 1 : tx_q << 1;
    assign rx_shift = lsb_q ? {MISO, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], MISO};

    assign TxReady = state_q == IDLE || state_q == WAIT;
    assign Busy    = state_q != IDLE;
    assign RxValid = rx_valid_q;
    assign RxData  = rx_data_q;
    assign SClk    = sclk_q;
    assign MOSI    = mosi_q;
    assign SS_n    = ss_n_q;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        last_d     = last_q;
        tick       = cnt_q == div_q;
        lead       = 1'b0;
        trail      = 1'b0;
        case (state_q)
            IDLE:  sclk_d = Cpol;
            SETUP: lead = tick;
            LEAD:  trail = tick;
            TRAIL: begin
                if (tick && bit_q < BW'(DATA_WIDTH)) begin
                    lead = 1'b1;
                end else if (tick) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_q;
                    state_d    = last_q ? CSHOLD : WAIT;
                end
            end
            CSHOLD: begin
                if (tick) begin
                    state_d = IDLE;
                    ss_n_d  = '1;
                end
            end
            default: ;
        endcase
        if (lead) begin
            state_d = LEAD;
            sclk_d  = ~cpol_q;
            if (cpha_q) begin
                mosi_d = out_bit;
                tx_d   = tx_shift;
            end else begin
                rx_d = rx_shift;
            end
        end
        if (trail) begin
            state_d = TRAIL;
            sclk_d  = cpol_q;
            bit_d   = bit_q + 1'b1;
            if (cpha_q) begin
                rx_d = rx_shift;
            end else if (bit_q != BW'(DATA_WIDTH - 1)) begin
                mosi_d = out_bit;
                tx_d   = tx_shift;
            end
        end
        // Mode and select are captured only when a frame opens from IDLE
        if (TxValid && TxReady) begin
            if (state_q == IDLE) begin
                cpol_d = Cpol;
                cpha_d = Cpha;
                lsb_d  = lsb_in;
                sclk_d = Cpol;
                ss_n_d = ~(NUM_SS'(1) << SsSel);
            end
            state_d = SETUP;
            last_d  = TxLast;
            div_d   = ClkDiv;
            bit_d   = '0;
            tx_d    = TxData;
            if (!cpha_d) begin
                mosi_d = lsb_d ? TxData[0] : TxData[DATA_WIDTH-1];
                tx_d   = lsb_d ? TxData >> 1 : TxData << 1;
            end
        end
        cnt_d = (state_d != state_q || state_q == IDLE || state_q == WAIT) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            last_q     <= last_d;
        end
    end
endmodule

// File: tb/tb_spi_master_mc.sv
// tb_spi_master_mc: vector table plus burst, select-hold and abort sequences for spi_master_mc.
// Received words are checked against a queue of expected words filled when each word is offered.
module tb_spi_master_mc;
    logic       Clk = 1'b0, Reset_n = 1'b0, TxValid = 1'b0, TxLast = 1'b0, Cpol = 1'b0, Cpha = 1'b0;
    logic [7:0] TxData = '0, ClkDiv = '0;
    logic [1:0] SsSel = '0;
    logic       TxReady, RxValid, Busy, SClk, MOSI, MISO;
    logic [7:0] RxData;
    logic [3:0] SS_n;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic       LsbFirst = 1'b0;
`endif

    spi_master_mc dut (
        .Clk(Clk), .Reset_n(Reset_n), .TxValid(TxValid), .TxReady(TxReady), .TxData(TxData),
        .TxLast(TxLast), .SsSel(SsSel), .Cpol(Cpol), .Cpha(Cpha), .ClkDiv(ClkDiv),
        .RxValid(RxValid), .RxData(RxData), .Busy(Busy), .SClk(SClk), .MOSI(MOSI), .MISO(MISO),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .LsbFirst(LsbFirst),
`endif
        .SS_n(SS_n)
    );

    always #5 Clk = ~Clk;

    int errors = 0, checks = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: counts SClk edges while selected and shifts out slave_m MSB first
    logic       loop_m = 1'b1, cpha_m = 1'b0, ps = 1'b0, slv_bit;
    logic [7:0] slave_m = '0;
    int         n = 0, idx;
    always @(SClk or SS_n) begin
        if (&SS_n) n = 0;
        else if (SClk !== ps) n = (n + 1) % 16;
        ps = SClk;
    end
    always_comb begin
        idx = cpha_m ? (n + 1) / 2 - 1 : n / 2;
        if (idx < 0) idx = 0;
        slv_bit = slave_m[7 - idx];
    end
    assign MISO = loop_m ? MOSI : slv_bit;

    logic [7:0] exp_q[$];
    int rx_cnt = 0;
    always @(negedge Clk) begin
        if (RxValid) begin
            rx_cnt++;
            check("rx_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("rx_data", RxData, exp_q.pop_front());
        end
    end

    int   rises = 0, chg = 0, run = 0, hp_min = 1000, hp_max = 0;
    logic sp = 1'b0;
    always @(negedge Clk) begin
        if (SClk !== sp) begin
            if (chg > 0) begin
                if (run < hp_min) hp_min = run;
                if (run > hp_max) hp_max = run;
            end
            chg++;
            if (SClk) rises++;
            run = 1;
        end else begin
            run++;
        end
        sp = SClk;
    end

    task automatic send(input logic [7:0] d, input logic last);
        int t = 0;
        TxData = d; TxLast = last; TxValid = 1'b1;
        while (!TxReady && t < 1000) begin @(negedge Clk); t++; end
        if (t >= 1000) check("ready_timeout", t, 0);
        @(posedge Clk); #1 TxValid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (Busy && t < 5000) begin @(negedge Clk); t++; end
        if (t >= 5000) check("busy_timeout", t, 0);
    endtask

    typedef struct {
        logic       cpol, cpha, loop;
        logic [7:0] div, tx, slv;
        logic [1:0] sel;
        logic [7:0] exp_rx;
    } vec_t;

    task automatic run_row(input vec_t v);
        int r0;
        logic [3:0] ss_e;
        Cpol = v.cpol; Cpha = v.cpha; ClkDiv = v.div; SsSel = v.sel;
        loop_m = v.loop; cpha_m = v.cpha; slave_m = v.slv;
        repeat (3) @(negedge Clk);
        rises = 0; chg = 0; hp_min = 1000; hp_max = 0; r0 = rx_cnt;
        exp_q.push_back(v.exp_rx);
        send(v.tx, 1'b1);
        @(negedge Clk);
        ss_e = ~(4'b0001 << v.sel);
        check("ss_sel", SS_n, ss_e);
        if (!v.cpha) check("mosi_first", MOSI, v.tx[7]);
        wait_idle();
        check("rx_count", rx_cnt - r0, 1);
        check("sclk_rises", rises, 8);
        check("half_min", hp_min, v.div + 1);
        check("half_max", hp_max, v.div + 1);
        check("sclk_idle", SClk, v.cpol);
        check("ss_idle", SS_n, 4'hF);
    endtask

    vec_t vecs[7];
    logic [7:0] bw[3];

    initial begin
        int r0, rdy, ss_hi, bad, i, t;
        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'd0, 8'hA5, 8'h00, 2'd0, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'd3, 8'h00, 8'h3C, 2'd0, 8'h3C};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'd3, 8'h5A, 8'h3C, 2'd0, 8'h3C};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'd3, 8'hF0, 8'h3C, 2'd0, 8'h3C};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'd1, 8'h96, 8'h00, 2'd3, 8'h96};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 8'd0, 8'hC3, 8'h00, 2'd1, 8'hC3};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 8'd2, 8'h0F, 8'h81, 2'd2, 8'h81};
        bw[0] = 8'h11; bw[1] = 8'h22; bw[2] = 8'h33;

        repeat (3) @(negedge Clk);
        check("rst_ss", SS_n, 4'hF);
        check("rst_sclk", SClk, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_busy", Busy, 0);
        check("rst_rxvalid", RxValid, 0);
        check("rst_rxdata", RxData, 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("idle_ready", TxReady, 1);

        for (int k = 0; k < 7; k++) run_row(vecs[k]);

        // Three-word burst: SS_n[0] must stay low and TxReady only rises in WAIT
        Cpol = 0; Cpha = 0; ClkDiv = 8'd1; SsSel = 2'd0; loop_m = 1'b1; cpha_m = 1'b0;
        repeat (3) @(negedge Clk);
        r0 = rx_cnt; rdy = 0; ss_hi = 0; i = 0;
        for (int k = 0; k < 3; k++) exp_q.push_back(bw[k]);
        TxData = bw[0]; TxLast = 1'b0; TxValid = 1'b1;
        for (int c = 0; c < 3000 && !(i == 3 && !Busy); c++) begin
            if (i > 0 && Busy) begin
                if (TxReady) rdy++;
                if (SS_n[0]) ss_hi++;
            end
            if (TxReady && i < 3) begin
                @(posedge Clk); #1;
                i++;
                if (i == 3) TxValid = 1'b0;
                else begin TxData = bw[i]; TxLast = (i == 2); end
            end
            @(negedge Clk);
        end
        TxValid = 1'b0;
        check("burst_words", i, 3);
        check("burst_rx", rx_cnt - r0, 3);
        check("burst_ready", rdy, 2);
        check("burst_ss_low", ss_hi, 0);
        check("burst_ss_end", SS_n, 4'hF);

        // Select changed mid-frame must not move SS_n
        SsSel = 2'd2; ClkDiv = 8'd2; Cpha = 1'b1; cpha_m = 1'b1;
        repeat (3) @(negedge Clk);
        rises = 0; bad = 0; t = 0;
        exp_q.push_back(8'h6B);
        send(8'h6B, 1'b1);
        while (Busy && t < 5000) begin
            if (rises >= 3) SsSel = 2'd1;
            if (SS_n !== 4'b1011) bad++;
            @(negedge Clk);
            t++;
        end
        check("sel_hold", bad, 0);
        check("sel_busy_end", Busy, 0);

        // Reset during bit 4 aborts the frame
        SsSel = 2'd0; ClkDiv = 8'd3; Cpha = 1'b0; cpha_m = 1'b0;
        repeat (3) @(negedge Clk);
        rises = 0; r0 = rx_cnt; t = 0;
        send(8'hF5, 1'b1);
        while (rises < 4 && t < 1000) begin @(negedge Clk); t++; end
        check("abort_reached_bit4", 32'(rises >= 4), 1);
        check("abort_pre_mosi", MOSI, 1);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        check("abort_ss", SS_n, 4'hF);
        check("abort_sclk", SClk, 0);
        check("abort_mosi", MOSI, 0);
        check("abort_busy", Busy, 0);
        check("abort_rxvalid", RxValid, 0);
        repeat (60) @(negedge Clk);
        check("abort_no_rx", rx_cnt - r0, 0);
        run_row('{1'b0, 1'b0, 1'b1, 8'd3, 8'h3E, 8'h00, 2'd0, 8'h3E});

`ifdef SPI_MASTER_LSB_FIRST_EN
        LsbFirst = 1'b1; ClkDiv = 8'd0; loop_m = 1'b1;
        repeat (3) @(negedge Clk);
        exp_q.push_back(8'h01);
        send(8'h01, 1'b1);
        @(negedge Clk);
        check("lsb_mosi_first", MOSI, 1);
        wait_idle();
        LsbFirst = 1'b0;
`endif

        repeat (5) @(negedge Clk);
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
